// File: rtl/data_mem_pipe_if.sv
// ---------------------------------------------------------------------------
// data_mem_pipe_if
//   Request/response bus for data_mem_pipe.
//   master : drives req_valid/req_we/req_addr/req_wdata/req_be, sees req_ready,
//            rsp_valid/rsp_rdata/rsp_err and init_busy.
//   slave  : the memory side (direction-reversed).
// ---------------------------------------------------------------------------
interface data_mem_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  init_busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );
endinterface

// File: rtl/data_mem_pipe.sv
// ---------------------------------------------------------------------------
// data_mem_pipe
//   Single-port word memory with byte-lane writes and a fixed-latency
//   response pipeline. After reset an init sweep writes INIT0 to word 0 and
//   zero to every other word (one word per cycle); requests are refused
//   until the sweep ends. Every accepted request returns exactly one
//   response RD_LAT cycles later; out-of-range addresses are flagged with
//   rsp_err, their writes are dropped and their reads return 0.
//
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (memory contents are kept)
//   bus  : data_mem_pipe_if.slave (request, response, init_busy)
// ---------------------------------------------------------------------------
module data_mem_pipe #(
   parameter int                DATA_W = 16,
   parameter int                ADDR_W = 16,
   parameter int                DEPTH  = 32768,
   parameter int                RD_LAT = 1,
   parameter logic [DATA_W-1:0] INIT0  = DATA_W'(16'h02BC)
) (
   input  logic             clk,
   input  logic             rst,
   data_mem_pipe_if.slave   bus
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic { S_INIT, S_RUN } state_t;

   state_t                           r_state;
   logic [IDX_W-1:0]                 r_ptr;
   logic                             r_busy;
   logic                             r_ready;
   logic [DATA_W-1:0]                r_mem [DEPTH];

   // Response pipeline; index 0 is loaded at the acceptance edge, the
   // output is taken from stage RD_LAT-1.
   logic [RD_LAT-1:0]                r_vld_pipe;
   logic [RD_LAT-1:0][DATA_W-1:0]    r_dat_pipe;
   logic [RD_LAT-1:0]                r_err_pipe;

   logic                             w_acc;
   logic                             w_in_rng;
   logic [IDX_W-1:0]                 w_idx;
   logic [DATA_W-1:0]                w_init_word;

   assign w_acc       = bus.req_valid & r_ready;
   // Compare one bit wider so DEPTH == 2**ADDR_W is representable.
   assign w_in_rng    = ({1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH));
   assign w_idx       = bus.req_addr[IDX_W-1:0];
   assign w_init_word = (r_ptr == '0) ? INIT0 : '0;

   // Sweep/run controller. Outputs are registered so ready/busy switch on
   // the same edge that writes the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_INIT;
         r_ptr   <= '0;
         r_busy  <= 1'b1;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               r_ptr <= r_ptr + 1'b1;
               if (r_ptr == IDX_W'(DEPTH-1)) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   // Storage has no reset: only the sweep clears it. While rst is held the
   // controller sits in S_INIT at pointer 0, so only word 0 is touched.
   always_ff @(posedge clk) begin
      if (r_state == S_INIT) begin
         r_mem[r_ptr] <= w_init_word;
      end else if (w_acc && bus.req_we && w_in_rng) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.req_be[b]) r_mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
         end
      end
   end

   // Read data is captured at the acceptance edge, so any write accepted on
   // an earlier edge is already visible. Non-responses carry zero data/err,
   // which keeps rsp_rdata/rsp_err at 0 whenever rsp_valid is 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_dat_pipe <= '0;
         r_err_pipe <= '0;
      end else begin
         r_vld_pipe[0] <= w_acc;
         r_dat_pipe[0] <= (w_acc && !bus.req_we && w_in_rng) ? r_mem[w_idx] : '0;
         r_err_pipe[0] <= w_acc && !w_in_rng;
         for (int s = 1; s < RD_LAT; s++) begin
            r_vld_pipe[s] <= r_vld_pipe[s-1];
            r_dat_pipe[s] <= r_dat_pipe[s-1];
            r_err_pipe[s] <= r_err_pipe[s-1];
         end
      end
   end

   assign bus.req_ready = r_ready;
   assign bus.init_busy = r_busy;
   assign bus.rsp_valid = r_vld_pipe[RD_LAT-1];
   assign bus.rsp_rdata = r_dat_pipe[RD_LAT-1];
   assign bus.rsp_err   = r_err_pipe[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_data_mem_pipe
//   Three instances (RD_LAT = 1, 2, 4; DEPTH = 16, DATA_W = 16) share one
//   directed request stream. Each request carries its hand-computed
//   response; a per-instance monitor checks arrival cycle, data and err.
// ---------------------------------------------------------------------------
module tb_data_mem_pipe;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   logic        t_valid = 1'b0;
   logic        t_we    = 1'b0;
   logic [15:0] t_addr  = '0;
   logic [15:0] t_wdata = '0;
   logic [1:0]  t_be    = '0;

   data_mem_pipe_if #(.DATA_W(16), .ADDR_W(16)) b1 ();
   data_mem_pipe_if #(.DATA_W(16), .ADDR_W(16)) b2 ();
   data_mem_pipe_if #(.DATA_W(16), .ADDR_W(16)) b4 ();

   assign b1.req_valid = t_valid;  assign b2.req_valid = t_valid;  assign b4.req_valid = t_valid;
   assign b1.req_we    = t_we;     assign b2.req_we    = t_we;     assign b4.req_we    = t_we;
   assign b1.req_addr  = t_addr;   assign b2.req_addr  = t_addr;   assign b4.req_addr  = t_addr;
   assign b1.req_wdata = t_wdata;  assign b2.req_wdata = t_wdata;  assign b4.req_wdata = t_wdata;
   assign b1.req_be    = t_be;     assign b2.req_be    = t_be;     assign b4.req_be    = t_be;

   data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .RD_LAT(1)) u_l1 (.clk(clk), .rst(rst), .bus(b1.slave));
   data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .RD_LAT(2)) u_l2 (.clk(clk), .rst(rst), .bus(b2.slave));
   data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .RD_LAT(4)) u_l4 (.clk(clk), .rst(rst), .bus(b4.slave));

   typedef struct {
      int          cyc;
      logic [15:0] d;
      logic        e;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t q4[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Response monitor for one instance.
   task automatic mon(input int l, input logic v, input logic [15:0] d, input logic e);
      exp_t x;
      int   sz;
      sz = (l == 1) ? q1.size() : (l == 2) ? q2.size() : q4.size();
      if (!v) begin
         chk($sformatf("L%0d idle", l), {15'd0, e, d}, 32'd0);
      end else if (sz == 0) begin
         chk($sformatf("L%0d spurious", l), {31'd0, v}, 32'd0);
      end else begin
         case (l)
            1:       x = q1.pop_front();
            2:       x = q2.pop_front();
            default: x = q4.pop_front();
         endcase
         chk($sformatf("L%0d cyc", l),   cyc,          x.cyc);
         chk($sformatf("L%0d rdata", l), {16'd0, d},   {16'd0, x.d});
         chk($sformatf("L%0d err", l),   {31'd0, e},   {31'd0, x.e});
      end
   endtask

   always @(negedge clk) mon(1, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err);
   always @(negedge clk) mon(2, b2.rsp_valid, b2.rsp_rdata, b2.rsp_err);
   always @(negedge clk) mon(4, b4.rsp_valid, b4.rsp_rdata, b4.rsp_err);

   // One accepted request per call; called at a negedge, returns one cycle later.
   task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] be, input logic [15:0] ed, input logic ee);
      t_valid = 1'b1; t_we = we; t_addr = a; t_wdata = wd; t_be = be;
      q1.push_back('{cyc + 1, ed, ee});
      q2.push_back('{cyc + 2, ed, ee});
      q4.push_back('{cyc + 4, ed, ee});
      @(negedge clk);
      t_valid = 1'b0;
   endtask

   // Counts cycles with init_busy high, starting in the current cycle.
   task automatic busy_count(input string tag);
      int n1 = 0, n2 = 0, n4 = 0, g = 0;
      while ((b1.init_busy || b2.init_busy || b4.init_busy) && g < 100) begin
         n1 += int'(b1.init_busy);
         n2 += int'(b2.init_busy);
         n4 += int'(b4.init_busy);
         g++;
         @(negedge clk);
      end
      chk({tag, " L1 busy"}, n1, 16);
      chk({tag, " L2 busy"}, n2, 16);
      chk({tag, " L4 busy"}, n4, 16);
      chk({tag, " L1 ready"}, {31'd0, b1.req_ready}, 32'd1);
      chk({tag, " L2 ready"}, {31'd0, b2.req_ready}, 32'd1);
      chk({tag, " L4 ready"}, {31'd0, b4.req_ready}, 32'd1);
   endtask

   task automatic drain(input string tag);
      repeat (6) @(negedge clk);
      chk({tag, " L1 q"}, q1.size(), 0);
      chk({tag, " L2 q"}, q2.size(), 0);
      chk({tag, " L4 q"}, q4.size(), 0);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst ready", {31'd0, b2.req_ready}, 32'd0);
      chk("rst busy",  {31'd0, b2.init_busy}, 32'd1);
      chk("rst valid", {31'd0, b4.rsp_valid}, 32'd0);

      rst = 1'b0;
      busy_count("sweep");

      //     we    addr    wdata     be     exp_rdata exp_err
      issue(1'b0, 16'd0,  16'h0000, 2'b00, 16'h02BC, 1'b0);
      issue(1'b0, 16'd5,  16'h0000, 2'b00, 16'h0000, 1'b0);
      issue(1'b1, 16'd3,  16'hA5A5, 2'b11, 16'h0000, 1'b0);
      issue(1'b1, 16'd3,  16'h1234, 2'b01, 16'h0000, 1'b0);
      issue(1'b0, 16'd3,  16'h0000, 2'b00, 16'hA534, 1'b0);
      issue(1'b1, 16'd7,  16'hBEEF, 2'b11, 16'h0000, 1'b0);
      issue(1'b0, 16'd7,  16'h0000, 2'b00, 16'hBEEF, 1'b0);
      issue(1'b1, 16'd7,  16'h0000, 2'b00, 16'h0000, 1'b0);
      issue(1'b0, 16'd7,  16'h0000, 2'b00, 16'hBEEF, 1'b0);
      issue(1'b1, 16'd20, 16'hFFFF, 2'b11, 16'h0000, 1'b1);
      issue(1'b0, 16'd20, 16'h0000, 2'b00, 16'h0000, 1'b1);
      issue(1'b0, 16'd4,  16'h0000, 2'b00, 16'h0000, 1'b0);
      issue(1'b0, 16'd15, 16'h0000, 2'b00, 16'h0000, 1'b0);
      issue(1'b0, 16'd16, 16'h0000, 2'b00, 16'h0000, 1'b1);
      drain("run");

      // Reset with L2/L4 responses still in flight: they must vanish.
      issue(1'b0, 16'd0, 16'h0000, 2'b00, 16'h02BC, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("midpipe L2 valid", {31'd0, b2.rsp_valid}, 32'd0);
      chk("midpipe L4 valid", {31'd0, b4.rsp_valid}, 32'd0);
      chk("midpipe ready",    {31'd0, b4.req_ready}, 32'd0);
      chk("midpipe busy",     {31'd0, b1.init_busy}, 32'd1);
      q1.delete(); q2.delete(); q4.delete();
      @(negedge clk);
      rst = 1'b0;

      // One-cycle reset at sweep cycle 8 restarts the full sweep.
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      busy_count("resweep");

      // The sweep cleared word 3 and restored word 0.
      issue(1'b0, 16'd3, 16'h0000, 2'b00, 16'h0000, 1'b0);
      issue(1'b0, 16'd0, 16'h0000, 2'b00, 16'h02BC, 1'b0);
      drain("end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, request address width.
REQ-003 Parameter DEPTH, default 32768, number of words, DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, response latency in cycles, legal range 1..4.
REQ-005 Parameter INIT0, default 16'h02BC (zero-extended to DATA_W), value loaded into word 0 by the init sweep.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 req_be  input  DATA_W/8  byte-lane write enables; lane i covers bits 8i+7:8i.
REQ-014 rsp_valid  output  1  response present, one-cycle pulse per accepted request.
REQ-015 rsp_rdata  output  DATA_W  read data; 0 for write responses.
REQ-016 rsp_err  output  1  accepted address was >= DEPTH.
REQ-017 init_busy  output  1  init sweep in progress.

Function
REQ-018 FSM states: INIT and RUN; rst forces INIT with sweep pointer 0.
REQ-019 INIT: one word per cycle, word 0 <= INIT0, words 1..DEPTH-1 <= 0; pointer increments each cycle.
REQ-020 INIT -> RUN on the edge that writes word DEPTH-1; the sweep takes exactly DEPTH cycles after rst deassertion.
REQ-021 init_busy = 1 in INIT, 0 in RUN; req_ready = 0 in INIT, 1 in RUN (no other backpressure).
REQ-022 A request is accepted on a rising edge where req_valid && req_ready.
REQ-023 Accepted write with in-range address: lanes with req_be[i]=1 updated at that edge, other lanes unchanged; req_be = 0 is a legal no-op write.
REQ-024 Accepted read: memory sampled at the acceptance edge; data reflects all writes accepted on earlier edges.
REQ-025 Same-address read accepted the cycle after a write: returns the new data (no stale read).
REQ-026 Every accepted request yields exactly one rsp_valid pulse exactly RD_LAT cycles after acceptance, in acceptance order; back-to-back requests yield back-to-back responses.
REQ-027 Responses cannot be stalled; there is no response-side ready.
REQ-028 Address >= DEPTH: write suppressed, read data forced to 0, rsp_err = 1 on that response; otherwise rsp_err = 0.
REQ-029 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid = 0.
REQ-030 req_wdata, req_be and req_we are don't-care when no request is accepted.

Reset
REQ-031 rst asserted: immediately rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0, init_busy = 1; latency pipeline flushed.
REQ-032 rst mid-sweep or mid-pipeline: in-flight responses are dropped and the sweep restarts from word 0.
REQ-033 Memory array contents are not cleared by rst itself; only the sweep clears them.

Verification (DEPTH=16, DATA_W=16, RD_LAT=2 unless stated)
REQ-034 Release rst -> init_busy high exactly 16 cycles, then req_ready=1; read addr 0 -> 16'h02BC, read addr 5 -> 16'h0000.
REQ-035 Write addr 3 = 16'hA5A5 with be=2'b11, then write addr 3 = 16'h1234 with be=2'b01, then read addr 3 -> 16'hA534.
REQ-036 Write addr 7 = 16'hBEEF, then read addr 7 the next cycle -> 16'hBEEF; rsp_valid pulses 2 cycles after each acceptance, in order.
REQ-037 Write addr 20 = 16'hFFFF -> rsp_err=1; then read addr 20 -> rdata 0, rsp_err=1; read addr 4 -> unchanged 16'h0000.
REQ-038 Assert rst at sweep cycle 8 for one cycle -> init_busy stays high a further 16 cycles after release; no rsp_valid during that time.
REQ-039 Repeat REQ-036 with RD_LAT=1 and RD_LAT=4 -> response latency 1 and 4 cycles respectively.
